// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold flags and handshake pulses
//
// Optional build macro: FIFO_FWFT_EN (first-word-fall-through read mode).
//
// Ports:
//   clk_a        in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   din_a        in   write data
//   wen_a        in   write request
//   ren_b        in   read request
//   dout_b       out  read data
//   valid        out  dout_b carries a freshly read word (level in FWFT mode)
//   wr_ack       out  previous-cycle write accepted
//   overflow     out  previous-cycle write rejected because full
//   underflow    out  previous-cycle read rejected because empty
//   full         out  count == FIFO_DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   data_count   out  words currently stored

module sync_fifo_flags #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                          clk_a,
  input  logic                          rst,
  input  logic [FIFO_WIDTH-1:0]         din_a,
  input  logic                          wen_a,
  input  logic                          ren_b,
  output logic [FIFO_WIDTH-1:0]         dout_b,
  output logic                          valid,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   data_count
);

  localparam int ADDR_SIZE = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = ADDR_SIZE + 1;

  localparam logic [CNT_W-1:0] DEPTH_LVL = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [CNT_W-1:0] AF_LVL    = AF_THRESH[CNT_W-1:0];
  localparam logic [CNT_W-1:0] AE_LVL    = AE_THRESH[CNT_W-1:0];

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 wr_ack_q, overflow_q, underflow_q;

  logic wr_en;
  logic rd_en;

  // Flags are decoded straight from the single occupancy counter so they
  // always describe the state left by the most recent edge.
  assign full         = (count_q == DEPTH_LVL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign data_count   = count_q;

  // Requests are ignored in the reset cycle; a full FIFO still accepts a read
  // and an empty one still accepts a write, so simultaneous requests at the
  // boundaries resolve to exactly one accepted operation.
  assign wr_en = wen_a && !full  && !rst;
  assign rd_en = ren_b && !empty && !rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage is never cleared; stale words are unreachable after reset
  // because both pointers and the count return to zero.
  always_ff @(posedge clk_a) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din_a;
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_en;
      overflow_q  <= wen_a && full;
      underflow_q <= ren_b && empty;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_FWFT_EN
  // Head of queue is presented combinationally; a pop simply advances
  // rd_ptr so the next word appears as soon as the pop edge has passed.
  assign dout_b = mem_q[rd_ptr_q];
  assign valid  = !empty;
`else
  logic [FIFO_WIDTH-1:0] dout_q;
  logic                  valid_q;

  // Registered read port: dout_q holds the last word read between pops.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        dout_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign dout_b = dout_q;
  assign valid  = valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags

module tb_sync_fifo_flags;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk_a = 1'b0;
  logic          rst;
  logic [W-1:0]  din_a;
  logic          wen_a;
  logic          ren_b;
  logic [W-1:0]  dout_b;
  logic          valid;
  logic          wr_ack;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    data_count;

  int checks = 0;
  int errors = 0;

  sync_fifo_flags #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk_a        (clk_a),
    .rst          (rst),
    .din_a        (din_a),
    .wen_a        (wen_a),
    .ren_b        (ren_b),
    .dout_b       (dout_b),
    .valid        (valid),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .underflow    (underflow),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count)
  );

  always #5 clk_a = ~clk_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  // One accepted pop expecting word exp: in FWFT mode the head is checked
  // before the pop edge, in registered mode the word appears after it.
  task automatic pop_step(input string tag, input logic [W-1:0] exp);
    ren_b = 1'b1;
`ifdef FIFO_FWFT_EN
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_dout"}, dout_b, exp);
    step();
`else
    step();
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_dout"}, dout_b, exp);
`endif
  endtask

  initial begin
    rst = 1'b1; wen_a = 1'b0; ren_b = 1'b0; din_a = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_empty", empty, 1'b1);
    chk("rst_aempty", almost_empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_afull", almost_full, 1'b0);
    chk("rst_count", data_count, 4'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_unf", underflow, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", dout_b, 16'h0);
`endif

    // Fill 1..8 and watch thresholds, then one rejected write
    for (int i = 1; i <= 8; i++) begin
      din_a = W'(i); wen_a = 1'b1;
      step();
      chk("fill_ack", wr_ack, 1'b1);
      chk("fill_ovf", overflow, 1'b0);
      chk("fill_count", data_count, 32'(i));
      chk("fill_full", full, (i == 8));
      chk("fill_afull", almost_full, (i >= AF));
      chk("fill_aempty", almost_empty, (i <= AE));
    end
    din_a = 16'h0009;
    step();
    chk("ovf_pulse", overflow, 1'b1);
    chk("ovf_ack", wr_ack, 1'b0);
    chk("ovf_count", data_count, 4'd8);
    wen_a = 1'b0;
    step();
    chk("ovf_clear", overflow, 1'b0);
    chk("ack_idle", wr_ack, 1'b0);

    // Drain in order, then one rejected read
    for (int i = 1; i <= 8; i++) begin
      pop_step("drain", W'(i));
      chk("drain_count", data_count, 32'(8 - i));
      chk("drain_empty", empty, (i == 8));
    end
    step();
    chk("unf_pulse", underflow, 1'b1);
    chk("unf_valid", valid, 1'b0);
    chk("unf_empty", empty, 1'b1);
    ren_b = 1'b0;
    step();
    chk("unf_clear", underflow, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("dout_hold", dout_b, 16'h0008);
`endif

    // Fill 4, then 20 cycles of simultaneous read/write across the wrap
    wen_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_a = 16'h0100 + W'(i);
      step();
    end
    chk("stream_start", data_count, 4'd4);
    for (int k = 0; k < 20; k++) begin
      din_a = 16'h0104 + W'(k);
      pop_step("stream", 16'h0100 + W'(k));
      chk("stream_count", data_count, 4'd4);
      chk("stream_ack", wr_ack, 1'b1);
    end
    ren_b = 1'b0;

    // Top up to full (contents 0x114..0x117, 0x200..0x203)
    for (int i = 0; i < 4; i++) begin
      din_a = 16'h0200 + W'(i);
      step();
    end
    chk("full_again", full, 1'b1);

    // Both at full: read taken, write refused
    din_a = 16'hDEAD;
    pop_step("bothfull", 16'h0114);
    chk("bothfull_ovf", overflow, 1'b1);
    chk("bothfull_ack", wr_ack, 1'b0);
    chk("bothfull_count", data_count, 4'd7);
    wen_a = 1'b0;
    pop_step("dr7", 16'h0115);
    pop_step("dr7", 16'h0116);
    pop_step("dr7", 16'h0117);
    for (int i = 0; i < 4; i++) begin
      pop_step("dr7", 16'h0200 + W'(i));
    end
    chk("dr7_empty", empty, 1'b1);

    // Both at empty: write taken, read refused
    wen_a = 1'b1; ren_b = 1'b1; din_a = 16'h0300;
    step();
    chk("bothempty_unf", underflow, 1'b1);
    chk("bothempty_ack", wr_ack, 1'b1);
    chk("bothempty_count", data_count, 4'd1);
    chk("bothempty_valid", valid, 1'b0 ^ 1'b0 | (data_count != 0 && `ifdef FIFO_FWFT_EN 1'b1 `else 1'b0 `endif));
    ren_b = 1'b0;

    // Fill to 5, then reset mid-stream with a write pending
    for (int i = 0; i < 4; i++) begin
      din_a = 16'h0400 + W'(i);
      step();
    end
    chk("pre_rst_count", data_count, 4'd5);
    rst = 1'b1; din_a = 16'h0999;
    step();
    chk("midrst_count", data_count, 4'd0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_ack", wr_ack, 1'b0);
    rst = 1'b0; wen_a = 1'b0;
    step();
    chk("postrst_count", data_count, 4'd0);

    // Single word into an empty FIFO
    wen_a = 1'b1; din_a = 16'hABCD;
    step();
    wen_a = 1'b0;
`ifdef FIFO_FWFT_EN
    chk("fwft_valid", valid, 1'b1);
    chk("fwft_dout", dout_b, 16'hABCD);
    ren_b = 1'b1;
    step();
    ren_b = 1'b0;
    chk("fwft_pop_valid", valid, 1'b0);
`else
    chk("std_novalid", valid, 1'b0);
    pop_step("std_single", 16'hABCD);
    ren_b = 1'b0;
    step();
    chk("std_valid_pulse", valid, 1'b0);
`endif
    chk("final_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
